// File: rtl/subbytes_sched_pkg.sv
// ----------------------------------------------------------------------------
// subbytes_sched_pkg : AES byte counts, scheduler state type, GF(2^8) multiply
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package subbytes_sched_pkg;

  localparam int AES_STATE_BYTES = 16;
  localparam int AES_WORD_BYTES  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sbox.sv
// ----------------------------------------------------------------------------
// sbox : combinational AES S-box (GF(2^8) inverse followed by affine map)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sbox import subbytes_sched_pkg::*; (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Inverse as x^254 (maps 0 to 0 as the S-box requires).
  assign x2   = gf_mul(din, din);
  assign x3   = gf_mul(x2, din);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign x252 = gf_mul(x240, x12);
  assign inv  = gf_mul(x252, x2);

  assign dout = inv
              ^ {inv[6:0], inv[7]}
              ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]}
              ^ 8'h63;

endmodule

`default_nettype wire

// File: rtl/subbytes_sched.sv
// ----------------------------------------------------------------------------
// subbytes_sched : LANES-wide S-box bank shared between round state and key word
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module subbytes_sched import subbytes_sched_pkg::*; #(
  parameter int LANES        = 4,
  parameter int KEY_PRIORITY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           st_valid,
  output logic                           st_ready,
  input  logic [AES_STATE_BYTES*8-1:0]   st_data,
  output logic                           st_out_valid,
  input  logic                           st_out_ready,
  output logic [AES_STATE_BYTES*8-1:0]   st_out_data,
  input  logic                           kw_valid,
  output logic                           kw_ready,
  input  logic [AES_WORD_BYTES*8-1:0]    kw_data,
  output logic                           kw_out_valid,
  output logic [AES_WORD_BYTES*8-1:0]    kw_out_data
);

  localparam int SW    = AES_STATE_BYTES * 8;
  localparam int LW    = LANES * 8;
  localparam int BEATS = AES_STATE_BYTES / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  state_e        state, state_nx;
  logic [CW-1:0] cnt;
  logic          rr;
  logic [SW-1:0] in_reg, res;
  logic [SW-1:0] in_shift, beat_mask, beat_res;
  logic [31:0]   shamt;
  logic [LW-1:0] beat_in, lane_in, lane_out;
  logic          key_grant, state_beat;

  // rr = 1 favours the key side; only consulted in round-robin mode while BUSY.
  assign kw_ready     = (KEY_PRIORITY != 0) ? 1'b1 : ((state != S_BUSY) || rr);
  assign key_grant    = kw_valid && kw_ready;
  assign state_beat   = (state == S_BUSY) && !key_grant;
  assign st_ready     = (state == S_IDLE);
  assign st_out_valid = (state == S_DONE);
  assign st_out_data  = res;

  assign shamt     = 32'(cnt) * 32'(LW);
  assign in_shift  = in_reg >> shamt;
  assign beat_in   = in_shift[LW-1:0];
  assign beat_mask = SW'({LW{1'b1}}) << shamt;
  assign beat_res  = SW'(lane_out) << shamt;

  generate
    for (genvar j = 0; j < LANES; j++) begin : g_lane
      if (j < AES_WORD_BYTES) begin : g_key_lane
        assign lane_in[8*j +: 8] = key_grant ? kw_data[8*j +: 8] : beat_in[8*j +: 8];
      end else begin : g_state_lane
        assign lane_in[8*j +: 8] = key_grant ? 8'h00 : beat_in[8*j +: 8];
      end
      sbox u_sbox (
        .din  (lane_in[8*j +: 8]),
        .dout (lane_out[8*j +: 8])
      );
    end
  endgenerate

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (st_valid) state_nx = S_BUSY;
      S_BUSY:  if (state_beat && (cnt == LAST_BEAT)) state_nx = S_DONE;
      S_DONE:  if (st_out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      rr           <= 1'b1;
      in_reg       <= '0;
      res          <= '0;
      kw_out_valid <= 1'b0;
      kw_out_data  <= '0;
    end else begin
      kw_out_valid <= key_grant;
      if (key_grant) kw_out_data <= lane_out[AES_WORD_BYTES*8-1:0];
      if ((state == S_IDLE) && st_valid) begin
        in_reg <= st_data;
        cnt    <= '0;
      end
      if (state_beat) begin
        res <= (res & ~beat_mask) | beat_res;
        cnt <= (cnt == LAST_BEAT) ? '0 : cnt + CW'(1);
      end
      if ((KEY_PRIORITY == 0) && (state == S_BUSY) && kw_valid) rr <= ~rr;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_subbytes_sched.sv
// ----------------------------------------------------------------------------
// tb_subbytes_sched : directed bench, instance 0 key-priority, instance 1 round-robin
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_subbytes_sched;

  localparam int LANES = 4;
  localparam int BEATS = 16 / LANES;
  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ALL_63   = {16{8'h63}};
  localparam logic [127:0] ALL_01   = {16{8'h01}};
  localparam logic [127:0] ALL_7C   = {16{8'h7c}};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         st_valid [2], st_ready [2], st_out_valid [2], st_out_ready [2];
  logic         kw_valid [2], kw_ready [2], kw_out_valid [2];
  logic [127:0] st_data [2], st_out_data [2];
  logic [31:0]  kw_data [2], kw_out_data [2];

  subbytes_sched #(.LANES(LANES), .KEY_PRIORITY(1)) dut_pri (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid[0]), .st_ready(st_ready[0]), .st_data(st_data[0]),
    .st_out_valid(st_out_valid[0]), .st_out_ready(st_out_ready[0]), .st_out_data(st_out_data[0]),
    .kw_valid(kw_valid[0]), .kw_ready(kw_ready[0]), .kw_data(kw_data[0]),
    .kw_out_valid(kw_out_valid[0]), .kw_out_data(kw_out_data[0])
  );

  subbytes_sched #(.LANES(LANES), .KEY_PRIORITY(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid[1]), .st_ready(st_ready[1]), .st_data(st_data[1]),
    .st_out_valid(st_out_valid[1]), .st_out_ready(st_out_ready[1]), .st_out_data(st_out_data[1]),
    .kw_valid(kw_valid[1]), .kw_ready(kw_ready[1]), .kw_data(kw_data[1]),
    .kw_out_valid(kw_out_valid[1]), .kw_out_data(kw_out_data[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference S-box: brute-force inverse search plus the FIPS-197 bitwise affine form.
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul_ref(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] sub_state(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sb[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sb[d[8*i +: 8]];
    return r;
  endfunction

  // Transaction model: rem = state beats still owed, done = result on offer.
  int           rem     [2];
  bit           done_m  [2];
  bit           rr_m    [2];
  bit           exp_kwv [2];
  logic [31:0]  exp_kwd [2];
  logic [127:0] exp_res [2];

  function automatic bit kwr_m(input int i);
    return (i == 0) || (rem[i] == 0) || rr_m[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        rem[i] <= 0; done_m[i] <= 1'b0; rr_m[i] <= 1'b1;
        exp_kwv[i] <= 1'b0; exp_kwd[i] <= '0; exp_res[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_kwv[i] <= kw_valid[i] && kwr_m(i);
        if (kw_valid[i] && kwr_m(i)) exp_kwd[i] <= sub_word(kw_data[i]);
        if (rem[i] > 0) begin
          if (i == 1 && kw_valid[i]) rr_m[i] <= !rr_m[i];
          if (!(kw_valid[i] && kwr_m(i))) begin
            rem[i] <= rem[i] - 1;
            if (rem[i] == 1) done_m[i] <= 1'b1;
          end
        end else if (done_m[i]) begin
          if (st_out_ready[i]) done_m[i] <= 1'b0;
        end else if (st_valid[i]) begin
          rem[i]     <= BEATS;
          exp_res[i] <= sub_state(st_data[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("mon%0d st_ready", i), 128'(st_ready[i]), 128'((rem[i] == 0) && !done_m[i]));
        check($sformatf("mon%0d st_out_valid", i), 128'(st_out_valid[i]), 128'(done_m[i]));
        if (done_m[i]) check($sformatf("mon%0d st_out_data", i), st_out_data[i], exp_res[i]);
        check($sformatf("mon%0d kw_ready", i), 128'(kw_ready[i]), 128'(kwr_m(i)));
        check($sformatf("mon%0d kw_out_valid", i), 128'(kw_out_valid[i]), 128'(exp_kwv[i]));
        if (exp_kwv[i]) check($sformatf("mon%0d kw_out_data", i), 128'(kw_out_data[i]), 128'(exp_kwd[i]));
      end
    end
  end

  task automatic start_job(input int i, input logic [127:0] d, output int acc);
    st_valid[i] = 1'b1;
    st_data[i]  = d;
    @(posedge clk);
    @(negedge clk);
    st_valid[i] = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_valid(input int i, input int acc, input int lat,
                            input logic [127:0] exp, input string name);
    for (int n = 0; n < 50 && !st_out_valid[i]; n++) @(negedge clk);
    check({name, " latency"}, 128'(cyc - acc), 128'(lat));
    check({name, " data"}, st_out_data[i], exp);
  endtask

  initial begin
    int acc;
    build_sbox();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st_valid[i] = 1'b0; st_data[i] = '0; st_out_ready[i] = 1'b1;
      kw_valid[i] = 1'b0; kw_data[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset%0d st_out_valid", i), 128'(st_out_valid[i]), 128'(0));
      check($sformatf("reset%0d kw_out_valid", i), 128'(kw_out_valid[i]), 128'(0));
      check($sformatf("reset%0d st_out_data", i), st_out_data[i], 128'(0));
      check($sformatf("reset%0d kw_out_data", i), 128'(kw_out_data[i]), 128'(0));
      check($sformatf("reset%0d st_ready", i), 128'(st_ready[i]), 128'(1));
      check($sformatf("reset%0d kw_ready", i), 128'(kw_ready[i]), 128'(1));
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Round-1 state, no key traffic, on both arbitration modes.
    start_job(0, FIPS_IN, acc);
    wait_valid(0, acc, 4, FIPS_OUT, "fips_pri");
    @(negedge clk);
    start_job(1, FIPS_IN, acc);
    wait_valid(1, acc, 4, FIPS_OUT, "fips_rr");
    @(negedge clk);

    // Lone key word while idle.
    kw_valid[0] = 1'b1; kw_data[0] = 32'hcf4f3c09;
    @(negedge clk);
    check("key_idle pulse", 128'(kw_out_valid[0]), 128'(1));
    check("key_idle data", 128'(kw_out_data[0]), 128'(32'h8a84eb01));
    kw_valid[0] = 1'b0;
    @(negedge clk);
    check("key_idle pulse_end", 128'(kw_out_valid[0]), 128'(0));
    check("key_idle data_hold", 128'(kw_out_data[0]), 128'(32'h8a84eb01));

    // Key priority: key request lands on state beat 2.
    start_job(0, FIPS_IN, acc);
    repeat (2) @(negedge clk);
    kw_valid[0] = 1'b1; kw_data[0] = 32'hcf4f3c09;
    @(negedge clk);
    check("pri_contend key_pulse", 128'(kw_out_valid[0]), 128'(1));
    check("pri_contend key_data", 128'(kw_out_data[0]), 128'(32'h8a84eb01));
    kw_valid[0] = 1'b0;
    wait_valid(0, acc, 5, FIPS_OUT, "pri_contend");
    @(negedge clk);

    // Round-robin: key held through BUSY, also granted on the accept cycle.
    kw_valid[1] = 1'b1; kw_data[1] = 32'hcf4f3c09;
    start_job(1, FIPS_IN, acc);
    check("rr_hold kw_ready_first", 128'(kw_ready[1]), 128'(1));
    @(negedge clk);
    check("rr_hold kw_ready_second", 128'(kw_ready[1]), 128'(0));
    check("rr_hold key_pulse", 128'(kw_out_valid[1]), 128'(1));
    wait_valid(1, acc, 8, FIPS_OUT, "rr_hold");
    kw_valid[1] = 1'b0;
    @(negedge clk);

    // Round-robin: rr left favouring state while kw_valid is low.
    start_job(1, '0, acc);
    kw_valid[1] = 1'b1; kw_data[1] = 32'h00000000;
    @(negedge clk);
    kw_valid[1] = 1'b0;
    check("rr_idle_req kw_data", 128'(kw_out_data[1]), 128'(32'h63636363));
    check("rr_idle_req kw_ready_low", 128'(kw_ready[1]), 128'(0));
    wait_valid(1, acc, 5, ALL_63, "rr_idle_req");
    @(negedge clk);

    // Backpressure on the state result.
    st_out_ready[0] = 1'b0;
    start_job(0, '0, acc);
    wait_valid(0, acc, 4, ALL_63, "bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp hold_valid%0d", k), 128'(st_out_valid[0]), 128'(1));
      check($sformatf("bp hold_data%0d", k), st_out_data[0], ALL_63);
      check($sformatf("bp hold_ready%0d", k), 128'(st_ready[0]), 128'(0));
    end
    st_out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp release st_ready", 128'(st_ready[0]), 128'(1));
    check("bp release st_out_valid", 128'(st_out_valid[0]), 128'(0));

    // Asynchronous reset during beat 1, then a fresh job.
    start_job(0, FIPS_IN, acc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid st_out_valid", 128'(st_out_valid[0]), 128'(0));
    check("rst_mid st_ready", 128'(st_ready[0]), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_job(0, ALL_01, acc);
    wait_valid(0, acc, 4, ALL_7C, "rst_mid new_job");
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/subbytes_sched.md
Name: subbytes_sched

Overview:
- Time-multiplexed SubBytes engine: one bank of LANES `sbox` instances, shared between two requesters.
- Requester 1 is the round datapath: a 128-bit state, processed in 16/LANES beats.
- Requester 2 is key expansion: a 32-bit SubWord, one beat.
- Replaces 16 parallel S-boxes (plus 4 more for key expansion) to save area. Sits between the round controller, key schedule and `sbox` bank.

Parameters:
- LANES, 4, number of `sbox` instances in the bank; legal values 4, 8, 16.
- KEY_PRIORITY, 1, 1 = key requester has strict priority; 0 = round-robin on contention.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  state job request
- st_ready  out  1  job accepted when st_valid & st_ready
- st_data  in  128  state in; byte i = bits [8i+7:8i]
- st_out_valid  out  1  result valid, held until st_out_ready
- st_out_ready  in  1  consumer accepts result
- st_out_data  out  128  substituted state; byte i = sbox(st_data byte i)
- kw_valid  in  1  key-word request
- kw_ready  out  1  key word granted this cycle
- kw_data  in  32  word for SubWord
- kw_out_valid  out  1  single-cycle pulse, no backpressure
- kw_out_data  out  32  sbox applied to each byte of kw_data, holds until next grant

Behaviour:
- Reset (async, rst_n low):
  - state IDLE, beat counter 0, round-robin bit favours key.
  - st_out_valid = 0, kw_out_valid = 0, st_out_data = 0, kw_out_data = 0.
  - Any job in flight is discarded; no partial result is ever presented.
- FSM states:
  - IDLE: st_ready = 1. On st_valid, capture st_data, clear counter, go to BUSY.
  - BUSY: st_ready = 0. Each state beat k processes bytes k*LANES .. k*LANES+LANES-1 through the bank, writes them to the result register and increments k. After beat 16/LANES-1, go to DONE.
  - DONE: st_ready = 0, st_out_valid = 1. When st_out_ready is high, go to IDLE. No accept in that same cycle (one-cycle bubble).
- Bank arbitration, evaluated each cycle:
  - Key grant (kw_ready = 1 and kw_valid) drives kw_data onto lanes 0-3. kw_out_data registers next edge and kw_out_valid pulses for one cycle (latency 1).
  - In a cycle with a key grant, the state beat stalls: counter and result are unchanged.
  - KEY_PRIORITY = 1: kw_ready is constant 1.
  - KEY_PRIORITY = 0, BUSY with kw_valid (contended): grant goes to the side the rr bit favours, and rr toggles after every contended cycle.
  - KEY_PRIORITY = 0, IDLE or DONE: kw_ready = 1.
  - KEY_PRIORITY = 0: kw_ready depends only on state and rr, never on kw_valid.
- Latency:
  - Uncontended state job accepted at edge N: st_out_valid is high after edge N + 16/LANES.
  - Each key grant during BUSY adds one cycle.
- Counter: width max(1, clog2(16/LANES)). It wraps to 0 on the BUSY→DONE transition.
- Unused lanes when LANES > 4 and a key beat is active: inputs driven 0, outputs ignored.
- Boundary cases:
  - A key grant on the same cycle as state acceptance is legal. The state job enters BUSY normally.
  - A key grant on the cycle BUSY→DONE would occur delays DONE by one cycle.
  - st_out_data is stable while st_out_valid is high.

Decomposition:
- Shared constants (AES_STATE_BYTES = 16, AES_WORD_BYTES = 4) go in the project-wide AES constants include.
- Natural sub-module: the existing `sbox`, instantiated LANES times via generate.
- The lane-select mux and FSM stay in subbytes_sched.

Test Plan:
- FIPS-197 round-1 state, LANES=4, no key traffic: st_data 193de3bea0f4e22b9ac68d2ae9f84808 → st_out_data d42711aee0bf98f1b8b45de51e415230, st_out_valid exactly 4 cycles after accept.
- Key word alone in IDLE: kw_data cf4f3c09 → kw_out_data 8a84eb01, kw_out_valid pulses 1 cycle after grant.
- Contention, KEY_PRIORITY=1: key request on beat 2 of the state job above → key result 8a84eb01 at +1, state result unchanged, delivered at accept+5.
- Contention, KEY_PRIORITY=0, kw_valid held through BUSY → grants alternate key/state; state done at accept+8; kw_ready never depends on kw_valid.
- Backpressure: st_out_ready low 5 cycles → st_out_valid and data held, st_ready 0; after release, IDLE, st_ready 1 next cycle; all-zero state → all 63.
- Reset mid-BUSY (beat 1) → st_out_valid 0, st_ready 1 immediately; new job of all 01 → all 7c, no stale bytes.
